// File: rtl/bound_flasher_ctrl_gen.sv
// Bound-flasher lamp controller: runs fill/drain/refill/drain/fill/drain lamp-count sequence
// with configurable bounds, step prescaler, pause, kickback, loop mode and done pulse.
module bound_flasher_ctrl_gen #(
    parameter int LAMP_NUM  = 16,
    parameter int B_LO      = 5,
    parameter int B_MID     = 10,
    parameter int DIV_RATIO = 1,
    localparam int CNT_W    = $clog2(LAMP_NUM + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flick,
    input  logic                hold,
    input  logic                loop_mode,
    output logic [CNT_W-1:0]    counter,
    output logic [LAMP_NUM-1:0] lamps,
    output logic                busy,
    output logic                done,
    output logic [2:0]          state_dbg
);

    localparam int PS_W = (DIV_RATIO > 1) ? $clog2(DIV_RATIO) : 1;

    if (!(B_LO > 0 && B_LO < B_MID && B_MID < LAMP_NUM && DIV_RATIO >= 1)) begin : g_param_check
        $error("bound_flasher_ctrl_gen: need 0 < B_LO < B_MID < LAMP_NUM and DIV_RATIO >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_UP1  = 3'd1,
        S_KB   = 3'd2,
        S_DN1  = 3'd3,
        S_UP2  = 3'd4,
        S_DN2  = 3'd5,
        S_UP3  = 3'd6,
        S_DN3  = 3'd7
    } state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    counter_n;
    logic [PS_W-1:0]     presc, presc_n;
    logic [LAMP_NUM-1:0] lamps_n;
    logic                done_n;
    logic                tick;

    assign tick      = (state != S_IDLE) && !hold && (presc == PS_W'(DIV_RATIO - 1));
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    always_comb begin
        state_n   = state;
        counter_n = counter;
        presc_n   = presc;
        done_n    = 1'b0;
        if (state == S_IDLE) begin
            counter_n = '0;
            presc_n   = '0;
            if (flick && !hold) begin
                state_n = S_UP1;
            end
        end else if (!hold) begin
            presc_n = tick ? '0 : presc + 1'b1;
            if (tick) begin
                case (state)
                    S_UP1: begin
                        if (flick && (counter == CNT_W'(B_LO) || counter == CNT_W'(B_MID))) begin
                            counter_n = counter - 1'b1;
                            // A kickback that already lands on 0 has nothing left to drain.
                            state_n   = (counter_n == '0) ? S_UP1 : S_KB;
                        end else begin
                            counter_n = counter + 1'b1;
                            if (counter_n == CNT_W'(LAMP_NUM)) state_n = S_DN1;
                        end
                    end
                    S_KB: begin
                        counter_n = counter - 1'b1;
                        if (counter_n == '0) state_n = S_UP1;
                    end
                    S_DN1: begin
                        counter_n = counter - 1'b1;
                        if (counter_n == CNT_W'(B_LO)) state_n = S_UP2;
                    end
                    S_UP2: begin
                        counter_n = counter + 1'b1;
                        if (counter_n == CNT_W'(B_MID)) state_n = S_DN2;
                    end
                    S_DN2: begin
                        counter_n = counter - 1'b1;
                        if (counter_n == '0) state_n = S_UP3;
                    end
                    S_UP3: begin
                        counter_n = counter + 1'b1;
                        if (counter_n == CNT_W'(B_LO)) state_n = S_DN3;
                    end
                    S_DN3: begin
                        counter_n = counter - 1'b1;
                        if (counter_n == '0) begin
                            state_n = loop_mode ? S_UP1 : S_IDLE;
                            done_n  = 1'b1;
                        end
                    end
                    default: begin
                        state_n   = S_IDLE;
                        counter_n = '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        lamps_n = '0;
        for (int i = 0; i < LAMP_NUM; i++) begin
            lamps_n[i] = (32'(counter_n) > 32'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            counter <= '0;
            lamps   <= '0;
            presc   <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            counter <= counter_n;
            lamps   <= lamps_n;
            presc   <= presc_n;
            done    <= done_n;
        end
    end

endmodule

// File: doc/bound_flasher_ctrl_gen.md
Name: bound_flasher_ctrl_gen

Overview:
Parametrised next-generation bound-flasher controller. Runs a fixed lamp-count sequence (fill, partial drain, partial refill, drain, short fill, drain) for LAMP_NUM lamps. Adds configurable bounds, a step-rate prescaler, a pause input, a continuous-loop mode, a thermometer lamp vector and an end-of-sequence pulse. It is the top-level control block driving the lamp bank.

Parameters:
LAMP_NUM, 16, number of lamps; sequence peak count
B_LO, 5, lower bound point
B_MID, 10, middle bound point; legal ranges are 0 < B_LO < B_MID < LAMP_NUM (elaboration-time check)
DIV_RATIO, 1, clock cycles per sequence step; must be >= 1
CNT_W (localparam), $clog2(LAMP_NUM+1), counter width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
flick  in  1  start request in IDLE; kickback request in UP1
hold  in  1  pause: freezes prescaler, state and counter
loop_mode  in  1  1 = restart UP1 after DN3 instead of going to IDLE
counter  out  CNT_W  number of lit lamps, 0..LAMP_NUM
lamps  out  LAMP_NUM  thermometer view: lamps[i] = (counter > i), registered
busy  out  1  1 whenever state != IDLE
done  out  1  one-cycle pulse on sequence completion

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counter=0, lamps=0, prescaler=0, done=0, busy=0. Reset mid-sequence aborts immediately.
- States: IDLE, UP1, KB, DN1, UP2, DN2, UP3, DN3.
- Prescaler runs only when state != IDLE and hold=0. Count 0..DIV_RATIO-1, then wrap. tick=1 when prescaler==DIV_RATIO-1 and hold=0. Prescaler clears on IDLE->UP1.
- IDLE: counter held at 0. flick=1 and hold=0 at a clock edge -> UP1 on that edge. The first increment happens on the next tick, which is DIV_RATIO edges later.
- Per tick, counter moves by exactly 1. The state changes on the same edge the counter reaches its target:
  - UP1: +1; counter_n==LAMP_NUM -> DN1
  - DN1: -1; counter_n==B_LO -> UP2
  - UP2: +1; counter_n==B_MID -> DN2
  - DN2: -1; counter_n==0 -> UP3
  - UP3: +1; counter_n==B_LO -> DN3
  - DN3: -1; counter_n==0 -> IDLE, or UP1 if loop_mode=1 on that edge
- Kickback: in UP1 on a tick with counter==B_LO or counter==B_MID and flick=1:
  - Decrement instead of increment and go to KB.
  - KB: -1 per tick; counter_n==0 -> UP1 (automatic restart, flick not needed).
  - flick is ignored in KB and in every other non-UP1 running state.
- done=1 for exactly one cycle following the DN3 edge where counter reaches 0, in both loop and non-loop mode.
- hold=1: no ticks; state, counter and prescaler frozen; flick ignored (including kickback). Releasing hold resumes the prescaler from its frozen value.
- Counter never under- or overflows: 0 <= counter <= LAMP_NUM in all states.
- Outputs counter, lamps and done are registered. busy is decoded from the state register.

Test Plan:
1. Defaults, hold=0, loop_mode=0; flick pulsed 1 cycle at edge 0 -> counter:
   - 1..16 at edges 1..16; 15..5 at edges 17..27; 6..10 at edges 28..32;
   - 9..0 at edges 33..42; 1..5 at edges 43..47; 4..0 at edges 48..52;
   - done=1 only in the cycle after edge 52; busy=0 afterwards.
2. flick=1 while counter==5 in UP1 (edge 6) -> counter 4 at edge 6, 0 at edge 10, state UP1, counter 1 at edge 11. Repeat with counter==10 -> drain to 0, then refill.
3. DIV_RATIO=4, flick at edge 0 -> counter steps 1,2,3 at edges 4,8,12. No change on any intermediate edge.
4. hold=1 for 7 cycles while counter==8 in DN1 -> counter, lamps and state unchanged; flick toggling ignored. After release the sequence resumes, and total length grows by exactly 7 cycles.
5. loop_mode=1 -> at edge 52 done pulses and state goes to UP1 (busy stays 1); counter=1 at edge 53.
6. rst_n asserted asynchronously mid-UP2 (counter=7) -> counter=0, lamps=0, busy=0 immediately without a clock edge. After release, IDLE waits for flick.
